// File: rtl/lab3_cache_backing_mem.sv
// Word-addressed backing memory behind the cache: fixed-latency, single-outstanding
// request/response port with byte/halfword access and an accepted-request counter.
module lab3_cache_backing_mem #(
  parameter int LATENCY   = 2,
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreq_val,
  output logic        memreq_rdy,
  input  logic [76:0] memreq_msg,
  output logic        memresp_val,
  input  logic        memresp_rdy,
  output logic [46:0] memresp_msg,
  output logic [31:0] req_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] mem [2**ADDR_BITS];

  // Request fields, packed MSB-first: type, opaque, addr, len, data
  logic [2:0]           req_type;
  logic [7:0]           req_opaque;
  logic [31:0]          req_addr;
  logic [1:0]           req_len;
  logic [31:0]          req_data;
  logic [ADDR_BITS-1:0] idx;
  logic [1:0]           off;

  assign req_type   = memreq_msg[76:74];
  assign req_opaque = memreq_msg[73:66];
  assign req_addr   = memreq_msg[65:34];
  assign req_len    = memreq_msg[33:32];
  assign req_data   = memreq_msg[31:0];
  assign idx        = req_addr[ADDR_BITS+1:2];
  assign off        = req_addr[1:0];

  logic accept, is_rd, is_wr;
  assign accept = memreq_val && memreq_rdy;
  assign is_rd  = (req_type == 3'd0);
  assign is_wr  = (req_type == 3'd1) || (req_type == 3'd2);

  logic [31:0] rd_word, rd_data;
  assign rd_word = mem[idx];

  always_comb begin
    rd_data = '0;
    if (is_rd) begin
      unique case (req_len)
        2'd1:    rd_data = {24'b0, rd_word[{off, 3'b000} +: 8]};
        2'd2:    rd_data = off[1] ? {16'b0, rd_word[31:16]} : {16'b0, rd_word[15:0]};
        default: rd_data = rd_word;
      endcase
    end
  end

  // Narrow writes replicate the payload across lanes and let the byte mask pick
  logic [3:0]  wmask;
  logic [31:0] wdata;
  always_comb begin
    wmask = 4'b1111;
    wdata = req_data;
    unique case (req_len)
      2'd1: begin
        wmask = 4'b0001 << off;
        wdata = {4{req_data[7:0]}};
      end
      2'd2: begin
        wmask = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{req_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Array is deliberately unreset; an accepted write commits even if reset follows
  always_ff @(posedge clk) begin
    if (accept && is_wr && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    memreq_rdy  = 1'b0;
    memresp_val = 1'b0;
    unique case (state)
      S_IDLE: begin
        memreq_rdy = 1'b1;
        if (memreq_val) state_nxt = (LATENCY == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: if (cnt == 4'd1) state_nxt = S_RESP;
      S_RESP: begin
        memresp_val = 1'b1;
        if (memresp_rdy) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      memresp_msg <= '0;
      req_count   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt         <= 4'(LATENCY);
        memresp_msg <= {req_type, req_opaque, 2'b00, req_len, rd_data};
        req_count   <= req_count + 32'd1;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_lab3_cache_backing_mem.sv
// Directed bench for the backing memory: a LATENCY=2 instance exercised through a
// scoreboarded transaction task, plus a LATENCY=0 instance checked for throughput.
module tb_lab3_cache_backing_mem;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        memreq_val, memreq_rdy, memresp_val, memresp_rdy;
  logic [76:0] memreq_msg;
  logic [46:0] memresp_msg;
  logic [31:0] req_count;

  logic        val0, rdy0, resp_val0, resp_rdy0;
  logic [76:0] msg0;
  logic [46:0] resp_msg0;
  logic [31:0] count0;

  int checks = 0;
  int fails  = 0;
  int cnt_m  = 0;
  logic [31:0] mdl [1024];
  logic [46:0] sb [$];

  always #5 clk = ~clk;

  lab3_cache_backing_mem #(.LATENCY(LAT), .ADDR_BITS(10)) dut (
    .clk(clk), .reset(reset),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
    .req_count(req_count)
  );

  lab3_cache_backing_mem #(.LATENCY(0), .ADDR_BITS(10)) dut0 (
    .clk(clk), .reset(reset),
    .memreq_val(val0), .memreq_rdy(rdy0), .memreq_msg(msg0),
    .memresp_val(resp_val0), .memresp_rdy(resp_rdy0), .memresp_msg(resp_msg0),
    .req_count(count0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference memory behaviour: returns response data, updates model array
  task automatic model(input logic [2:0] t, input logic [31:0] a, input logic [1:0] l,
                       input logic [31:0] d, output logic [31:0] r);
    logic [31:0] w;
    int o;
    w = mdl[a[11:2]];
    o = int'(a[1:0]);
    r = 32'h0;
    if (t == 3'd0) begin
      if (l == 2'd1)      r = {24'h0, w[o*8 +: 8]};
      else if (l == 2'd2) r = a[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
      else                r = w;
    end else if (t == 3'd1 || t == 3'd2) begin
      if (l == 2'd1)      w[o*8 +: 8] = d[7:0];
      else if (l == 2'd2) begin
        if (a[1]) w[31:16] = d[15:0];
        else      w[15:0]  = d[15:0];
      end else            w = d;
      mdl[a[11:2]] = w;
    end
  endtask

  task automatic txn(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                     input logic [1:0] l, input logic [31:0] d, input int stall);
    logic [31:0] r;
    logic [46:0] held, exp;
    int n;
    @(negedge clk);
    memreq_msg = {t, op, a, l, d};
    memreq_val = 1'b1;
    n = 0;
    while (!memreq_rdy && n < 20) begin @(negedge clk); n++; end
    chk("req_rdy", 64'(memreq_rdy), 64'd1);
    @(posedge clk);
    #1 memreq_val = 1'b0;
    model(t, a, l, d, r);
    sb.push_back({t, op, 2'b00, l, r});
    cnt_m++;
    @(negedge clk);
    n = 0;
    while (!memresp_val && n < 40) begin @(negedge clk); n++; end
    chk("latency", 64'(n), 64'(LAT));
    held = memresp_msg;
    repeat (stall) begin
      @(negedge clk);
      chk("bp_val", 64'(memresp_val), 64'd1);
      chk("bp_msg", 64'(memresp_msg), 64'(held));
      chk("bp_req_rdy", 64'(memreq_rdy), 64'd0);
    end
    exp = sb.pop_front();
    chk("resp_msg", 64'(memresp_msg), 64'(exp));
    chk("req_count", 64'(req_count), 64'(cnt_m));
    memresp_rdy = 1'b1;
    @(posedge clk);
    #1 memresp_rdy = 1'b0;
    @(negedge clk);
    chk("idle_req_rdy", 64'(memreq_rdy), 64'd1);
    chk("idle_resp_val", 64'(memresp_val), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    memreq_val = 1'b0; memresp_rdy = 1'b0; memreq_msg = '0;
    val0 = 1'b0; resp_rdy0 = 1'b1; msg0 = '0;
    #23;
    chk("rst_req_rdy", 64'(memreq_rdy), 64'd1);
    chk("rst_resp_val", 64'(memresp_val), 64'd0);
    chk("rst_resp_msg", 64'(memresp_msg), 64'd0);
    chk("rst_count", 64'(req_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Zero-latency instance: requests held valid are taken every other cycle
    @(negedge clk);
    msg0 = {3'd2, 8'h5A, 32'h0000_0040, 2'd0, 32'h0BAD_F00D};
    val0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("l0_req_rdy", 64'(rdy0), 64'((i % 2) == 0));
      chk("l0_resp_val", 64'(resp_val0), 64'((i % 2) == 1));
      if (i == 1) chk("l0_resp_msg", 64'(resp_msg0), 64'({3'd2, 8'h5A, 2'b00, 2'd0, 32'h0}));
    end
    val0 = 1'b0;
    @(negedge clk);
    chk("l0_count", 64'(count0), 64'd5);

    // Write/read round trip
    txn(3'd1, 8'h11, 32'h0000_0010, 2'd0, 32'hDEAD_BEEF, 0);
    txn(3'd0, 8'h12, 32'h0000_0010, 2'd0, 32'h0, 0);
    chk("t1_data", 64'(mdl[4]), 64'h0000_0000_DEAD_BEEF);

    // Byte/halfword access
    txn(3'd2, 8'h21, 32'h0000_0020, 2'd0, 32'h1122_3344, 0);
    txn(3'd1, 8'h22, 32'h0000_0021, 2'd1, 32'hFFFF_FFAA, 0);
    txn(3'd0, 8'h23, 32'h0000_0020, 2'd0, 32'h0, 0);
    txn(3'd0, 8'h24, 32'h0000_0022, 2'd1, 32'h0, 0);
    txn(3'd0, 8'h25, 32'h0000_0022, 2'd2, 32'h0, 0);
    txn(3'd1, 8'h26, 32'h0000_0020, 2'd2, 32'hCAFE_BEEF, 0);
    txn(3'd0, 8'h27, 32'h0000_0020, 2'd3, 32'h0, 0);
    txn(3'd5, 8'h28, 32'h0000_0020, 2'd0, 32'hFFFF_FFFF, 0);
    txn(3'd0, 8'h29, 32'h0000_0020, 2'd0, 32'h0, 0);

    // Address aliasing above the array size
    txn(3'd1, 8'h51, 32'h0000_1004, 2'd0, 32'h0000_0055, 0);
    txn(3'd0, 8'h52, 32'h0000_0004, 2'd0, 32'h0, 0);

    // Backpressure on the response
    txn(3'd0, 8'h31, 32'h0000_0010, 2'd0, 32'h0, 5);

    // Reset while a write is waiting: response dropped, write kept
    @(negedge clk);
    memreq_msg = {3'd1, 8'h61, 32'h0000_0030, 2'd0, 32'h0000_0077};
    memreq_val = 1'b1;
    @(posedge clk);
    #1 memreq_val = 1'b0;
    begin
      logic [31:0] r;
      model(3'd1, 32'h0000_0030, 2'd0, 32'h0000_0077, r);
    end
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_resp_val", 64'(memresp_val), 64'd0);
    chk("mid_rst_count", 64'(req_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    cnt_m = 0;
    txn(3'd0, 8'h62, 32'h0000_0030, 2'd0, 32'h0, 0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
